proc_controller: RTL and testbench
==================================

PROC_CONTROLLER -- requirements
Module: proc_controller

Interface
REQ-001 Parameters SHALL be (name, default, meaning): IW 16 instruction width; OPW 4 opcode width; RA_W 4 register-address width; DA_W 8 data-address width; PCW 8 jump-target width; ALU_SW 3 ALU-select width; MAX_WAIT 15 load wait-cycle limit; CNT_W 16 retired-instruction counter width.
REQ-002 Legal parameters SHALL satisfy IW >= OPW+3*RA_W, IW >= OPW+RA_W+DA_W and IW >= OPW+PCW; elaboration SHALL fail otherwise.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high. Ports (name direction width meaning):
  Clock in 1 rising-edge clock
  Reset in 1 synchronous active-high reset
  IR in IW instruction; opcode = IR[IW-1 -: OPW]
  D_rdy in 1 data memory read data valid
  ALU_zero in 1 ALU result-zero flag
  Resume in 1 leave HALT
  PC_clr, PC_up, PC_ld out 1 each: PC clear, PC increment, PC load
  PC_ld_addr out PCW PC load value
  IR_ld out 1 instruction register load
  D_wr out 1 data memory write
  D_addr out DA_W data memory address
  RF_s out 2 write-data select: 0 ALU, 1 memory, 2 immediate
  Imm out DA_W zero-extended immediate
  ALU_s out ALU_SW ALU operation select
  RF_W_en out 1; RF_W_addr, RF_Ra_addr, RF_Rb_addr out RA_W each
  stateOut out 4 current state code
  Halted, Error out 1 each
  InstrCount out CNT_W retired-instruction count

Function
REQ-004 Outputs SHALL be combinational from the state register and IR; strobes and addresses SHALL be 0 in every state not listed for them.
REQ-005 Fields: Ra = IR[IW-OPW-1 -: RA_W]; Rb = the next RA_W bits below Ra; Rw = IR[RA_W-1:0]; Dlo = IR[DA_W-1:0]; Dmid = IR[RA_W+DA_W-1:RA_W]; Tgt = IR[PCW-1:0].
REQ-006 State codes: INIT 0, FETCH 1, DECODE 2, NOOP 3, STORE 4, LOAD_A 5, LOAD_B 6, ADD 7, SUB 8, LDI 9, JPZ 10, HALT 11, ERR 12; stateOut SHALL equal the code.
REQ-007 INIT: PC_clr=1; next FETCH.
REQ-008 FETCH: IR_ld=1, PC_up=1, ALU_s=3; next DECODE. IR is valid from DECODE until the next FETCH.
REQ-009 DECODE: no strobes. Opcode 0->NOOP, 1->STORE, 2->LOAD_A, 3->ADD, 4->SUB, 5->HALT, 6->LDI, 7->JPZ; any other opcode->ERR.
REQ-010 InstrCount SHALL increment (modulo 2^CNT_W) on every DECODE cycle with a legal opcode; it SHALL not change otherwise.
REQ-011 ADD/SUB: RF_Ra_addr=Ra, RF_Rb_addr=Rb, RF_W_addr=Rw, RF_W_en=1, RF_s=0, ALU_s=1 (ADD) / 2 (SUB); next FETCH.
REQ-012 STORE: RF_Ra_addr=Ra, D_addr=Dlo, D_wr=1; next FETCH.
REQ-013 LOAD_A: D_addr=Dmid, RF_W_addr=Rw, RF_s=1. A wait counter SHALL clear on entry and increment on each LOAD_A cycle with D_rdy=0. D_rdy=1 -> LOAD_B. D_rdy=0 with counter==MAX_WAIT -> ERR. Otherwise stay. D_rdy=1 wins over timeout in the same cycle.
REQ-014 LOAD_B: D_addr=Dmid, RF_W_addr=Rw, RF_s=1, RF_W_en=1; next FETCH.
REQ-015 LDI: Imm=Dmid, RF_W_addr=Rw, RF_s=2, RF_W_en=1; next FETCH.
REQ-016 JPZ: PC_ld_addr=Tgt; PC_ld=ALU_zero; next FETCH.
REQ-017 NOOP: next FETCH.
REQ-018 HALT: Halted=1; Resume=1 -> FETCH, else stay. Resume SHALL be ignored in all other states.
REQ-019 ERR: Error=1; stay until Reset.

Reset
REQ-020 Reset=1 at a rising edge SHALL, in any state including mid-LOAD wait, set state to INIT, clear InstrCount and the wait counter, and take priority over D_rdy and Resume.
REQ-021 Required values in the cycle after reset: stateOut=0, PC_clr=1, all other strobes 0, all addresses/Imm 0, Halted=0, Error=0, InstrCount=0.

Verification
REQ-022 Reset, release, IR=16'h3731 -> INIT, FETCH, DECODE, ADD in successive cycles; in ADD: Ra=7, Rb=3, W_addr=1, ALU_s=1, RF_W_en=1; InstrCount=1.
REQ-023 IR=16'h2A53, D_rdy low 3 cycles then high -> LOAD_A for 4 cycles with D_addr=8'hA5, then LOAD_B with RF_W_en=1, RF_W_addr=3, RF_s=1.
REQ-024 IR=16'h2A53, D_rdy held low -> LOAD_A for 16 cycles, then ERR with Error=1 until Reset.
REQ-025 IR=16'h7042 with ALU_zero=1 -> PC_ld=1, PC_ld_addr=8'h42; with ALU_zero=0 -> PC_ld=0. IR=16'h6FF2 -> Imm=8'hFF, RF_s=2, RF_W_addr=2.
REQ-026 IR=16'h5000 -> HALT, Halted=1 while Resume=0; pulse Resume -> FETCH the next cycle. IR=16'hB000 -> ERR, InstrCount unchanged.
REQ-027 Reset asserted during LOAD_A with D_rdy=1 at the same edge -> INIT, InstrCount=0.

Source files
------------

// File: rtl/proc_controller.sv
`default_nettype none
// ============================================================================
// Module : proc_controller
// Brief  : Fetch/decode/execute sequencer with a bounded load wait and a
//          retired-instruction counter.
// Rev    : 1.0  initial release
// ============================================================================
module proc_controller #(
  parameter int IW       = 16,
  parameter int OPW      = 4,
  parameter int RA_W     = 4,
  parameter int DA_W     = 8,
  parameter int PCW      = 8,
  parameter int ALU_SW   = 3,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [IW-1:0]     IR,
  input  logic              D_rdy,
  input  logic              ALU_zero,
  input  logic              Resume,
  output logic              PC_clr,
  output logic              PC_up,
  output logic              PC_ld,
  output logic [PCW-1:0]    PC_ld_addr,
  output logic              IR_ld,
  output logic              D_wr,
  output logic [DA_W-1:0]   D_addr,
  output logic [1:0]        RF_s,
  output logic [DA_W-1:0]   Imm,
  output logic [ALU_SW-1:0] ALU_s,
  output logic              RF_W_en,
  output logic [RA_W-1:0]   RF_W_addr,
  output logic [RA_W-1:0]   RF_Ra_addr,
  output logic [RA_W-1:0]   RF_Rb_addr,
  output logic [3:0]        stateOut,
  output logic              Halted,
  output logic              Error,
  output logic [CNT_W-1:0]  InstrCount
);

  generate
    if ((IW < OPW + 3*RA_W) || (IW < OPW + RA_W + DA_W) || (IW < OPW + PCW)) begin : g_bad_params
      $error("proc_controller: IW too narrow for the instruction fields");
    end
  endgenerate

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_STORE  = 4'd4,
    S_LOAD_A = 4'd5,
    S_LOAD_B = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_LDI    = 4'd9,
    S_JPZ    = 4'd10,
    S_HALT   = 4'd11,
    S_ERR    = 4'd12
  } state_t;

  // Wide enough to hold MAX_WAIT even when MAX_WAIT is 0
  localparam int                c_WAIT_W   = $clog2(MAX_WAIT + 2);
  localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MAX_WAIT);

  localparam logic [OPW-1:0] c_OP_NOOP  = OPW'(0);
  localparam logic [OPW-1:0] c_OP_STORE = OPW'(1);
  localparam logic [OPW-1:0] c_OP_LOAD  = OPW'(2);
  localparam logic [OPW-1:0] c_OP_ADD   = OPW'(3);
  localparam logic [OPW-1:0] c_OP_SUB   = OPW'(4);
  localparam logic [OPW-1:0] c_OP_HALT  = OPW'(5);
  localparam logic [OPW-1:0] c_OP_LDI   = OPW'(6);
  localparam logic [OPW-1:0] c_OP_JPZ   = OPW'(7);

  state_t              r_state;
  logic [c_WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]    r_count;

  logic [OPW-1:0]  w_opcode;
  logic [RA_W-1:0] w_ra;
  logic [RA_W-1:0] w_rb;
  logic [RA_W-1:0] w_rw;
  logic [DA_W-1:0] w_dlo;
  logic [DA_W-1:0] w_dmid;
  logic [PCW-1:0]  w_tgt;
  state_t          w_dec_state;
  logic            w_legal;

  assign w_opcode = IR[IW-1 -: OPW];
  assign w_ra     = IR[IW-OPW-1 -: RA_W];
  assign w_rb     = IR[IW-OPW-RA_W-1 -: RA_W];
  assign w_rw     = IR[RA_W-1:0];
  assign w_dlo    = IR[DA_W-1:0];
  assign w_dmid   = IR[RA_W+DA_W-1:RA_W];
  assign w_tgt    = IR[PCW-1:0];

  always_comb begin
    w_dec_state = S_ERR;
    w_legal     = 1'b1;
    case (w_opcode)
      c_OP_NOOP:  w_dec_state = S_NOOP;
      c_OP_STORE: w_dec_state = S_STORE;
      c_OP_LOAD:  w_dec_state = S_LOAD_A;
      c_OP_ADD:   w_dec_state = S_ADD;
      c_OP_SUB:   w_dec_state = S_SUB;
      c_OP_HALT:  w_dec_state = S_HALT;
      c_OP_LDI:   w_dec_state = S_LDI;
      c_OP_JPZ:   w_dec_state = S_JPZ;
      default:    w_legal     = 1'b0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_INIT;
      r_wait  <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_INIT:   r_state <= S_FETCH;
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          r_state <= w_dec_state;
          r_wait  <= '0;
          if (w_legal) r_count <= r_count + CNT_W'(1);
        end
        // Data-ready beats the timeout when both happen in the same cycle
        S_LOAD_A: begin
          if (D_rdy)                      r_state <= S_LOAD_B;
          else if (r_wait == c_WAIT_MAX)  r_state <= S_ERR;
          else                            r_wait  <= r_wait + c_WAIT_W'(1);
        end
        S_HALT:   if (Resume) r_state <= S_FETCH;
        S_ERR:    r_state <= S_ERR;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    PC_ld      = 1'b0;
    PC_ld_addr = '0;
    IR_ld      = 1'b0;
    D_wr       = 1'b0;
    D_addr     = '0;
    RF_s       = 2'd0;
    Imm        = '0;
    ALU_s      = '0;
    RF_W_en    = 1'b0;
    RF_W_addr  = '0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    Halted     = 1'b0;
    Error      = 1'b0;
    case (r_state)
      S_INIT:  PC_clr = 1'b1;
      S_FETCH: begin
        IR_ld = 1'b1;
        PC_up = 1'b1;
        ALU_s = ALU_SW'(3);
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = w_ra;
        RF_Rb_addr = w_rb;
        RF_W_addr  = w_rw;
        RF_W_en    = 1'b1;
        ALU_s      = (r_state == S_ADD) ? ALU_SW'(1) : ALU_SW'(2);
      end
      S_STORE: begin
        RF_Ra_addr = w_ra;
        D_addr     = w_dlo;
        D_wr       = 1'b1;
      end
      S_LOAD_A, S_LOAD_B: begin
        D_addr    = w_dmid;
        RF_W_addr = w_rw;
        RF_s      = 2'd1;
        RF_W_en   = (r_state == S_LOAD_B);
      end
      S_LDI: begin
        Imm       = w_dmid;
        RF_W_addr = w_rw;
        RF_s      = 2'd2;
        RF_W_en   = 1'b1;
      end
      S_JPZ: begin
        PC_ld_addr = w_tgt;
        PC_ld      = ALU_zero;
      end
      S_HALT:  Halted = 1'b1;
      S_ERR:   Error  = 1'b1;
      default: ;
    endcase
  end

  assign stateOut   = r_state;
  assign InstrCount = r_count;

endmodule
`default_nettype wire

// File: tb/tb_proc_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_proc_controller
// Brief  : Self-checking bench for proc_controller (vectors, corner sequences,
//          randomized run against a reference model).
// Rev    : 1.0  initial release
// ============================================================================
module tb_proc_controller;

  localparam int IW = 16, OPW = 4, RA_W = 4, DA_W = 8, PCW = 8;
  localparam int ALU_SW = 3, MAX_WAIT = 15, CNT_W = 16;

  logic              Clock = 1'b0;
  logic              Reset, D_rdy, ALU_zero, Resume;
  logic [IW-1:0]     IR;
  logic              PC_clr, PC_up, PC_ld, IR_ld, D_wr, RF_W_en, Halted, Error;
  logic [PCW-1:0]    PC_ld_addr;
  logic [DA_W-1:0]   D_addr, Imm;
  logic [1:0]        RF_s;
  logic [ALU_SW-1:0] ALU_s;
  logic [RA_W-1:0]   RF_W_addr, RF_Ra_addr, RF_Rb_addr;
  logic [3:0]        stateOut;
  logic [CNT_W-1:0]  InstrCount;

  proc_controller dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .D_rdy(D_rdy), .ALU_zero(ALU_zero),
    .Resume(Resume), .PC_clr(PC_clr), .PC_up(PC_up), .PC_ld(PC_ld),
    .PC_ld_addr(PC_ld_addr), .IR_ld(IR_ld), .D_wr(D_wr), .D_addr(D_addr),
    .RF_s(RF_s), .Imm(Imm), .ALU_s(ALU_s), .RF_W_en(RF_W_en),
    .RF_W_addr(RF_W_addr), .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
    .stateOut(stateOut), .Halted(Halted), .Error(Error), .InstrCount(InstrCount)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Reference model: state code, wait count, retired count
  int               m_state = 0;
  int               m_wait  = 0;
  logic [CNT_W-1:0] m_count = '0;
  int               dec_tbl [8] = '{3, 4, 5, 7, 8, 11, 9, 10};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t model_state=%0d)", name, act, exp, $time, m_state);
    end
  endtask

  task automatic model_next();
    int op;
    if (Reset) begin
      m_state = 0; m_wait = 0; m_count = '0;
    end else begin
      case (m_state)
        0: m_state = 1;
        1: m_state = 2;
        2: begin
          op = int'(IR[15:12]);
          if (op < 8) begin
            m_state = dec_tbl[op];
            m_count = m_count + 1'b1;
            m_wait  = 0;
          end else m_state = 12;
        end
        5: begin
          if (D_rdy) m_state = 6;
          else if (m_wait == MAX_WAIT) m_state = 12;
          else m_wait++;
        end
        11: if (Resume) m_state = 1;
        12: m_state = 12;
        default: m_state = 1;
      endcase
    end
  endtask

  task automatic check_all();
    logic ex, ld;
    ex = (m_state == 7) || (m_state == 8);
    ld = (m_state == 5) || (m_state == 6);
    chk("stateOut", stateOut, m_state);
    chk("PC_clr", PC_clr, m_state == 0);
    chk("PC_up", PC_up, m_state == 1);
    chk("IR_ld", IR_ld, m_state == 1);
    chk("PC_ld", PC_ld, (m_state == 10) && ALU_zero);
    chk("PC_ld_addr", PC_ld_addr, (m_state == 10) ? IR[7:0] : 8'h00);
    chk("D_wr", D_wr, m_state == 4);
    chk("D_addr", D_addr, (m_state == 4) ? IR[7:0] : ld ? IR[11:4] : 8'h00);
    chk("RF_s", RF_s, ld ? 2'd1 : (m_state == 9) ? 2'd2 : 2'd0);
    chk("Imm", Imm, (m_state == 9) ? IR[11:4] : 8'h00);
    chk("ALU_s", ALU_s, (m_state == 1) ? 3'd3 : (m_state == 7) ? 3'd1 : (m_state == 8) ? 3'd2 : 3'd0);
    chk("RF_W_en", RF_W_en, ex || (m_state == 6) || (m_state == 9));
    chk("RF_W_addr", RF_W_addr, (ex || ld || m_state == 9) ? IR[3:0] : 4'h0);
    chk("RF_Ra_addr", RF_Ra_addr, (ex || m_state == 4) ? IR[11:8] : 4'h0);
    chk("RF_Rb_addr", RF_Rb_addr, ex ? IR[7:4] : 4'h0);
    chk("Halted", Halted, m_state == 11);
    chk("Error", Error, m_state == 12);
    chk("InstrCount", InstrCount, m_count);
  endtask

  task automatic step();
    model_next();
    @(posedge Clock);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    chk("rst_state", stateOut, 0);
    chk("rst_count", InstrCount, 0);
    Reset = 1'b0;
  endtask

  task automatic run_to_exec(input logic [15:0] ir, input logic az);
    do_reset();
    IR = ir;
    ALU_zero = az;
    step();
    chk("seq_fetch", stateOut, 1);
    step();
    chk("seq_decode", stateOut, 2);
    step();
  endtask

  typedef struct {
    logic [15:0] ir;
    logic        az;
    int          st;
    logic        we;
    logic [3:0]  wa;
    logic [2:0]  alu;
    logic        pcld;
    int          cnt;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int n;
    vecs[0] = '{16'h3731, 1'b0, 7,  1'b1, 4'h1, 3'd1, 1'b0, 1};
    vecs[1] = '{16'h4A5C, 1'b0, 8,  1'b1, 4'hC, 3'd2, 1'b0, 1};
    vecs[2] = '{16'h7042, 1'b1, 10, 1'b0, 4'h0, 3'd0, 1'b1, 1};
    vecs[3] = '{16'h7042, 1'b0, 10, 1'b0, 4'h0, 3'd0, 1'b0, 1};
    vecs[4] = '{16'h6FF2, 1'b0, 9,  1'b1, 4'h2, 3'd0, 1'b0, 1};
    vecs[5] = '{16'h1123, 1'b0, 4,  1'b0, 4'h0, 3'd0, 1'b0, 1};
    vecs[6] = '{16'h0000, 1'b0, 3,  1'b0, 4'h0, 3'd0, 1'b0, 1};
    vecs[7] = '{16'hB000, 1'b0, 12, 1'b0, 4'h0, 3'd0, 1'b0, 0};
    vecs[8] = '{16'hF123, 1'b1, 12, 1'b0, 4'h0, 3'd0, 1'b0, 0};
    vecs[9] = '{16'h5000, 1'b0, 11, 1'b0, 4'h0, 3'd0, 1'b0, 1};

    Reset = 1'b1; IR = '0; D_rdy = 1'b0; ALU_zero = 1'b0; Resume = 1'b0;
    do_reset();
    chk("rst_pc_clr", PC_clr, 1);

    for (int i = 0; i < 10; i++) begin
      run_to_exec(vecs[i].ir, vecs[i].az);
      chk("vec_state", stateOut, vecs[i].st);
      chk("vec_we", RF_W_en, vecs[i].we);
      chk("vec_waddr", RF_W_addr, vecs[i].wa);
      chk("vec_alu", ALU_s, vecs[i].alu);
      chk("vec_pcld", PC_ld, vecs[i].pcld);
      chk("vec_count", InstrCount, vecs[i].cnt);
    end
    chk("add_ra", 32'(vecs[0].ir[11:8]), 7);

    // Load with three not-ready cycles
    D_rdy = 1'b0;
    run_to_exec(16'h2A53, 1'b0);
    chk("load_daddr", D_addr, 8'hA5);
    n = 0;
    while (stateOut == 4'd5 && n < 40) begin
      n++;
      D_rdy = (n >= 4);
      step();
    end
    chk("load_cycles", n, 4);
    chk("loadb_state", stateOut, 6);
    chk("loadb_we", RF_W_en, 1);
    chk("loadb_waddr", RF_W_addr, 3);
    chk("loadb_rfs", RF_s, 1);
    D_rdy = 1'b0;

    // Load timeout
    run_to_exec(16'h2A53, 1'b0);
    n = 0;
    while (stateOut == 4'd5 && n < 40) begin
      n++;
      step();
    end
    chk("timeout_cycles", n, 16);
    for (int k = 0; k < 3; k++) begin
      Resume = 1'b1;
      step();
      chk("err_sticky", Error, 1);
    end
    Resume = 1'b0;

    // Halt and resume
    run_to_exec(16'h5000, 1'b0);
    step();
    step();
    chk("halt_hold", Halted, 1);
    Resume = 1'b1;
    step();
    chk("resume_fetch", stateOut, 1);
    Resume = 1'b0;

    // Reset beats D_rdy mid-load
    run_to_exec(16'h2A53, 1'b0);
    step();
    Reset = 1'b1;
    D_rdy = 1'b1;
    step();
    chk("rst_load_state", stateOut, 0);
    chk("rst_load_count", InstrCount, 0);
    Reset = 1'b0;
    D_rdy = 1'b0;

    // Randomized run
    for (int c = 0; c < 1500; c++) begin
      IR       = {4'($urandom_range(0, 9)), 12'($urandom)};
      D_rdy    = ($urandom_range(0, 9) < 3);
      Resume   = ($urandom_range(0, 4) == 0);
      ALU_zero = 1'($urandom);
      Reset    = ($urandom_range(0, 59) == 0) || (m_state == 12 && $urandom_range(0, 3) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
